// File: rtl/arbitro_memoria.sv
// Arbiter for the shared board-memory port. VGA owns the port by default. Validador, colisor
// and pontuacao take it during blanking, or right after another owner releases it.
module arbitro_memoria #(
    parameter int MIN_PONT = 12,
    parameter int MAX_HOLD = 1024,
    parameter int GAP      = 1
) (
    input  logic       clk,
    input  logic       resetGeral,
    input  logic       req_validador,
    input  logic       jog_validador,
    input  logic       req_colisor,
    input  logic       jog_colisor,
    input  logic       req_pontuacao,
    input  logic       jog_pontuacao,
    input  logic       jog_vga,
    input  logic       vga_blank,
    output logic       gnt_validador,
    output logic       gnt_colisor,
    output logic       gnt_pontuacao,
    output logic       gnt_vga,
    output logic [1:0] sel,
    output logic       jogador,
    output logic       wr_allow,
    output logic       timeout
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] PONT_LAST = HW'(MIN_PONT - 1);
    localparam logic [1:0]    GAP_LAST  = 2'(GAP - 1);

    localparam logic [1:0] SRC_VGA   = 2'd0;
    localparam logic [1:0] SRC_VALID = 2'd1;
    localparam logic [1:0] SRC_COLIS = 2'd2;
    localparam logic [1:0] SRC_PONT  = 2'd3;

    typedef enum logic [2:0] {S_VGA, S_GAP, S_VALID, S_COLIS, S_PONT} state_t;

    function automatic state_t owner_state(input logic [1:0] src);
        case (src)
            SRC_VALID: owner_state = S_VALID;
            SRC_COLIS: owner_state = S_COLIS;
            SRC_PONT:  owner_state = S_PONT;
            default:   owner_state = S_VGA;
        endcase
    endfunction

    state_t        r_state, w_state_next;
    logic [1:0]    r_tgt, w_tgt_next;
    logic          r_tgt_ok, w_tgt_ok_next;
    logic          r_jog, w_jog_next;
    logic [1:0]    r_gap_cnt, w_gap_next;
    logic [HW-1:0] r_hold_cnt, w_hold_next, w_hold_inc;
    logic [HW-1:0] r_wait_cnt, w_wait_next;
    logic          r_mask_v, r_mask_c, r_mask_p;
    logic          w_mask_v_next, w_mask_c_next, w_mask_p_next;
    logic          r_forced, w_forced_next;

    logic          r_gnt_v, r_gnt_c, r_gnt_p, r_gnt_g;
    logic [1:0]    r_sel;
    logic          r_jog_out, r_wr, r_timeout;

    logic          w_req_v, w_req_c, w_req_p, w_any, w_starve;
    logic [1:0]    w_win;
    logic          w_win_jog;

    // A requester that timed out stays masked until it drops its request.
    assign w_req_v    = req_validador & ~r_mask_v;
    assign w_req_c    = req_colisor   & ~r_mask_c;
    assign w_req_p    = req_pontuacao & ~r_mask_p;
    assign w_any      = w_req_v | w_req_c | w_req_p;
    assign w_starve   = w_req_p && (r_wait_cnt == HOLD_MAX);
    assign w_hold_inc = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + HW'(1);

    always_comb begin
        w_win     = SRC_PONT;
        w_win_jog = jog_pontuacao;
        if (w_starve) begin
            w_win     = SRC_PONT;
            w_win_jog = jog_pontuacao;
        end else if (w_req_v) begin
            w_win     = SRC_VALID;
            w_win_jog = jog_validador;
        end else if (w_req_c) begin
            w_win     = SRC_COLIS;
            w_win_jog = jog_colisor;
        end
    end

    always_comb begin
        if (r_state == S_PONT || !w_req_p)
            w_wait_next = '0;
        else if (r_wait_cnt == HOLD_MAX)
            w_wait_next = r_wait_cnt;
        else
            w_wait_next = r_wait_cnt + HW'(1);
    end

    always_comb begin
        w_state_next  = r_state;
        w_tgt_next    = r_tgt;
        w_tgt_ok_next = r_tgt_ok;
        w_jog_next    = r_jog;
        w_gap_next    = r_gap_cnt;
        w_hold_next   = r_hold_cnt;
        w_forced_next = 1'b0;
        w_mask_v_next = r_mask_v & req_validador;
        w_mask_c_next = r_mask_c & req_colisor;
        w_mask_p_next = r_mask_p & req_pontuacao;

        case (r_state)
            S_VGA: begin
                if (w_any && vga_blank) begin
                    w_state_next  = S_GAP;
                    w_gap_next    = '0;
                    w_tgt_next    = w_win;
                    w_tgt_ok_next = 1'b1;
                    w_jog_next    = w_win_jog;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_tgt_ok_next = 1'b0;
                    w_hold_next   = '0;
                    if (r_tgt_ok) begin
                        w_state_next = owner_state(r_tgt);
                    end else if (w_any) begin
                        // Re-arbitration after a release does not wait for blanking.
                        w_state_next = owner_state(w_win);
                        w_tgt_next   = w_win;
                        w_jog_next   = w_win_jog;
                    end else begin
                        w_state_next = S_VGA;
                    end
                end else begin
                    w_gap_next = r_gap_cnt + 2'd1;
                end
            end
            S_VALID, S_COLIS: begin
                if (!((r_state == S_VALID) ? req_validador : req_colisor)) begin
                    w_state_next  = S_GAP;
                    w_gap_next    = '0;
                    w_tgt_ok_next = 1'b0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_next  = S_GAP;
                    w_gap_next    = '0;
                    w_tgt_ok_next = 1'b0;
                    w_forced_next = 1'b1;
                    if (r_state == S_VALID) w_mask_v_next = 1'b1;
                    else                    w_mask_c_next = 1'b1;
                end else begin
                    w_hold_next = w_hold_inc;
                end
            end
            S_PONT: begin
                if (req_pontuacao && r_hold_cnt == HOLD_LAST) begin
                    w_state_next  = S_GAP;
                    w_gap_next    = '0;
                    w_tgt_ok_next = 1'b0;
                    w_forced_next = 1'b1;
                    w_mask_p_next = 1'b1;
                end else if (!req_pontuacao && r_hold_cnt >= PONT_LAST) begin
                    w_state_next  = S_GAP;
                    w_gap_next    = '0;
                    w_tgt_ok_next = 1'b0;
                end else begin
                    w_hold_next = w_hold_inc;
                end
            end
            default: w_state_next = S_VGA;
        endcase
    end

    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            r_state    <= S_VGA;
            r_tgt      <= SRC_VGA;
            r_tgt_ok   <= 1'b0;
            r_jog      <= 1'b0;
            r_gap_cnt  <= '0;
            r_hold_cnt <= '0;
            r_wait_cnt <= '0;
            r_mask_v   <= 1'b0;
            r_mask_c   <= 1'b0;
            r_mask_p   <= 1'b0;
            r_forced   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tgt      <= w_tgt_next;
            r_tgt_ok   <= w_tgt_ok_next;
            r_jog      <= w_jog_next;
            r_gap_cnt  <= w_gap_next;
            r_hold_cnt <= w_hold_next;
            r_wait_cnt <= w_wait_next;
            r_mask_v   <= w_mask_v_next;
            r_mask_c   <= w_mask_c_next;
            r_mask_p   <= w_mask_p_next;
            r_forced   <= w_forced_next;
        end
    end

    // Outputs are a registered decode of the state, one cycle behind the arbitration decision.
    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            r_gnt_g   <= 1'b1;
            r_gnt_v   <= 1'b0;
            r_gnt_c   <= 1'b0;
            r_gnt_p   <= 1'b0;
            r_sel     <= SRC_VGA;
            r_jog_out <= 1'b0;
            r_wr      <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_gnt_g   <= (r_state == S_VGA);
            r_gnt_v   <= (r_state == S_VALID);
            r_gnt_c   <= (r_state == S_COLIS);
            r_gnt_p   <= (r_state == S_PONT);
            r_sel     <= (r_state == S_VALID) ? SRC_VALID :
                         (r_state == S_COLIS) ? SRC_COLIS :
                         (r_state == S_PONT)  ? SRC_PONT  : SRC_VGA;
            r_jog_out <= r_jog;
            r_wr      <= (r_state == S_VALID) || (r_state == S_COLIS);
            r_timeout <= r_forced;
        end
    end

    assign gnt_validador = r_gnt_v;
    assign gnt_colisor   = r_gnt_c;
    assign gnt_pontuacao = r_gnt_p;
    assign gnt_vga       = r_gnt_g;
    assign sel           = r_sel;
    assign jogador       = r_gnt_g ? jog_vga : r_jog_out;
    assign wr_allow      = r_wr;
    assign timeout       = r_timeout;
endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria: cycle table for the basic handoffs, hand-written
// sequences for the pontuacao window, hold timeout and asynchronous reset.
module tb_arbitro_memoria;
    logic       clk = 1'b0;
    logic       resetGeral;
    logic       req_validador, jog_validador, req_colisor, jog_colisor;
    logic       req_pontuacao, jog_pontuacao, jog_vga, vga_blank;
    logic       gnt_validador, gnt_colisor, gnt_pontuacao, gnt_vga;
    logic [1:0] sel;
    logic       jogador, wr_allow, timeout;

    int checks   = 0;
    int failures = 0;

    // in = {req_v, jog_v, req_c, jog_c, req_p, jog_p, jog_vga, vga_blank}
    // gnt = {validador, colisor, pontuacao, vga}
    typedef struct {
        logic [7:0] in;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       jog;
        logic       chk_jog;
        logic       wr;
        string      name;
    } vec_t;
    vec_t vecs[$];

    localparam logic [3:0] G_V = 4'b1000, G_C = 4'b0100, G_P = 4'b0010, G_G = 4'b0001, G_N = 4'b0000;

    always #5 clk = ~clk;

    arbitro_memoria #(.MIN_PONT(12), .MAX_HOLD(1024), .GAP(1)) dut (
        .clk(clk), .resetGeral(resetGeral),
        .req_validador(req_validador), .jog_validador(jog_validador),
        .req_colisor(req_colisor), .jog_colisor(jog_colisor),
        .req_pontuacao(req_pontuacao), .jog_pontuacao(jog_pontuacao),
        .jog_vga(jog_vga), .vga_blank(vga_blank),
        .gnt_validador(gnt_validador), .gnt_colisor(gnt_colisor),
        .gnt_pontuacao(gnt_pontuacao), .gnt_vga(gnt_vga),
        .sel(sel), .jogador(jogador), .wr_allow(wr_allow), .timeout(timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_in(input logic [7:0] v);
        {req_validador, jog_validador, req_colisor, jog_colisor,
         req_pontuacao, jog_pontuacao, jog_vga, vga_blank} = v;
    endtask

    task automatic av(input logic [7:0] in, input logic [3:0] g, input logic [1:0] s,
                      input logic j, input logic cj, input logic w, input string nm);
        vec_t v;
        v.in = in; v.gnt = g; v.sel = s; v.jog = j; v.chk_jog = cj; v.wr = w; v.name = nm;
        vecs.push_back(v);
    endtask

    function automatic logic [3:0] gnts();
        return {gnt_validador, gnt_colisor, gnt_pontuacao, gnt_vga};
    endfunction

    function automatic logic inv_ok();
        return ($countones(gnts()) <= 1) && (wr_allow == (gnt_validador | gnt_colisor));
    endfunction

    initial begin
        logic [8:0] act, expv;
        int cnt_p, last_p, first_v, bad;
        int cnt_v, last_v, n_to, to_c, regrant;

        resetGeral = 1'b0;
        apply_in(8'h00);
        repeat (2) tick();
        chk("reset_state", 32'({gnts(), sel, wr_allow, timeout, jogador}), 32'({G_G, 2'd0, 3'b000}));
        resetGeral = 1'b1;
        tick();
        chk("reset_release", 32'({gnts(), sel, wr_allow, timeout, jogador}), 32'({G_G, 2'd0, 3'b000}));
        jog_vga = 1'b1;
        #1;
        chk("jog_vga_follow", 32'(jogador), 32'(1));
        jog_vga = 1'b0;
        $display("reset sequence done");

        // Colisor waits 20 cycles outside blanking, then is granted through one gap cycle.
        for (int i = 0; i < 20; i++) av(8'b0011_0000, G_G, 2'd0, 1'b0, 1'b1, 1'b0, "colis_wait");
        av(8'b0011_0001, G_G, 2'd0, 1'b0, 1'b1, 1'b0, "colis_blank");
        av(8'b0011_0000, G_N, 2'd0, 1'b0, 1'b0, 1'b0, "colis_gap");
        av(8'b0010_0000, G_C, 2'd2, 1'b1, 1'b1, 1'b1, "colis_gnt");
        av(8'b0010_0000, G_C, 2'd2, 1'b1, 1'b1, 1'b1, "colis_hold");
        av(8'b0000_0000, G_C, 2'd2, 1'b1, 1'b1, 1'b1, "colis_drop");
        av(8'b0000_0000, G_N, 2'd0, 1'b0, 1'b0, 1'b0, "colis_rel_gap");
        av(8'b0000_0000, G_G, 2'd0, 1'b0, 1'b1, 1'b0, "colis_vga");
        av(8'b0000_0010, G_G, 2'd0, 1'b1, 1'b1, 1'b0, "vga_jog");
        // Validador and pontuacao in the same blanking cycle; pontuacao follows without blank.
        av(8'b1000_1101, G_G, 2'd0, 1'b0, 1'b1, 1'b0, "vp_blank");
        av(8'b1000_1100, G_N, 2'd0, 1'b0, 1'b0, 1'b0, "vp_gap");
        av(8'b1000_1100, G_V, 2'd1, 1'b0, 1'b1, 1'b1, "vp_gnt_v");
        av(8'b0000_1100, G_V, 2'd1, 1'b0, 1'b1, 1'b1, "vp_drop_v");
        av(8'b0000_1100, G_N, 2'd0, 1'b0, 1'b0, 1'b0, "vp_gap2");
        av(8'b0000_1100, G_P, 2'd3, 1'b1, 1'b1, 1'b0, "vp_gnt_p");
        for (int i = 0; i < 11; i++) av(8'b0000_0000, G_P, 2'd3, 1'b1, 1'b1, 1'b0, "pont_min");
        av(8'b0000_0000, G_N, 2'd0, 1'b0, 1'b0, 1'b0, "pont_gap");
        av(8'b0000_0000, G_G, 2'd0, 1'b0, 1'b1, 1'b0, "pont_vga");

        foreach (vecs[i]) begin
            apply_in(vecs[i].in);
            tick();
            act  = {gnts(), sel, jogador & vecs[i].chk_jog, wr_allow, timeout};
            expv = {vecs[i].gnt, vecs[i].sel, vecs[i].jog & vecs[i].chk_jog, vecs[i].wr, 1'b0};
            chk(vecs[i].name, 32'(act), 32'(expv));
            $display("vec %0d %s gnt=%b sel=%0d jog=%b wr=%b to=%b",
                     i, vecs[i].name, gnts(), sel, jogador, wr_allow, timeout);
        end

        // Pontuacao pulsed 3 cycles keeps the port 12 cycles; validador raised mid-window waits.
        apply_in(8'h00);
        cnt_p = 0; last_p = -1; first_v = -1; bad = 0;
        for (int c = 0; c < 40; c++) begin
            req_pontuacao = (c < 3);
            vga_blank     = (c == 0);
            req_validador = (c >= 6) && (first_v < 0);
            tick();
            if (gnt_pontuacao) begin cnt_p++; last_p = c; end
            if (gnt_validador && first_v < 0) first_v = c;
            if (!inv_ok()) bad++;
        end
        chk("pont_window", 32'(cnt_p), 32'(12));
        chk("pont_to_valid_gap", 32'(first_v - last_p), 32'(2));
        chk("pont_invariants", 32'(bad), 32'(0));
        chk("pont_end_vga", 32'(gnt_vga), 32'(1));
        $display("pont window: cycles=%0d last_p=%0d first_v=%0d", cnt_p, last_p, first_v);

        // Validador holds 1100 cycles with blanking always on: forced release after 1024.
        apply_in(8'h00);
        cnt_v = 0; last_v = -1; n_to = 0; to_c = -1; regrant = 0; bad = 0;
        for (int c = 0; c < 1115; c++) begin
            req_validador = (c < 1100) || (c >= 1105);
            vga_blank     = 1'b1;
            tick();
            if (gnt_validador) begin
                if (c < 1105) begin cnt_v++; last_v = c; end
                else regrant = 1;
            end
            if (timeout) begin n_to++; to_c = c; end
            if (!inv_ok()) bad++;
        end
        chk("hold_cycles", 32'(cnt_v), 32'(1024));
        chk("timeout_pulses", 32'(n_to), 32'(1));
        chk("timeout_align", 32'(to_c - last_v), 32'(1));
        chk("regrant_after_fall", 32'(regrant), 32'(1));
        chk("hold_invariants", 32'(bad), 32'(0));
        req_validador = 1'b0;
        vga_blank     = 1'b0;
        for (int c = 0; c < 10 && !gnt_vga; c++) tick();
        chk("timeout_back_vga", 32'(gnt_vga), 32'(1));
        $display("timeout: grant_cycles=%0d pulses=%0d at=%0d regrant=%0d", cnt_v, n_to, to_c, regrant);

        // Asynchronous reset in the middle of a colisor ownership.
        req_colisor = 1'b1; jog_colisor = 1'b1; vga_blank = 1'b1;
        tick();
        vga_blank = 1'b0;
        tick();
        tick();
        chk("colis_owned", 32'({gnt_colisor, wr_allow}), 32'(2'b11));
        #2 resetGeral = 1'b0;
        #1;
        chk("async_reset", 32'({gnt_colisor, wr_allow, gnt_vga, sel}), 32'(5'b00100));
        req_colisor = 1'b0;
        tick();
        resetGeral = 1'b1;
        tick();
        chk("post_reset", 32'({gnts(), sel, wr_allow}), 32'({G_G, 2'd0, 1'b0}));
        $display("async reset sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
